// File: rtl/history_window_counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | history_window_counter_pkg : default parameters and clog2 helper        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package history_window_counter_pkg;

  localparam int DEF_HIST_W = 32;
  localparam int DEF_WIN    = 3;
  localparam int DEF_THRESH = 2;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/history_window_counter_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_popcount : combinational WIN-bit popcount with threshold vote     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module window_popcount #(
  parameter int WIN    = 3,
  parameter int CNT_W  = 2,
  parameter int THRESH = 2
) (
  input  logic [WIN-1:0]   bits,
  output logic [CNT_W-1:0] cnt,
  output logic             vote
);

  localparam logic [31:0] C_THRESH = THRESH;

  logic [31:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < WIN; i++) begin
      w_sum = w_sum + 32'(bits[i]);
    end
  end

  assign cnt  = w_sum[CNT_W-1:0];
  // Compare the full-width sum so THRESH > WIN simply never votes.
  assign vote = (w_sum >= C_THRESH);

endmodule
`default_nettype wire

// File: rtl/history_window_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | history_window_counter : sliding-window popcount over outcome history    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module history_window_counter
  import history_window_counter_pkg::*;
#(
  parameter  int HIST_W = DEF_HIST_W,
  parameter  int WIN    = DEF_WIN,
  parameter  int THRESH = DEF_THRESH,
  localparam int CNT_W  = clog2(WIN + 1),
  localparam int NWIN   = HIST_W - WIN + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  input  logic                  upd_taken,
  input  logic                  clr,
  output logic [HIST_W-1:0]     hist,
  output logic [NWIN*CNT_W-1:0] win_cnt,
  output logic [NWIN-1:0]       win_vote,
  output logic                  out_valid,
  output logic                  hist_full
);

  localparam int                FILL_W   = clog2(HIST_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HIST_W);

  logic [FILL_W-1:0]     r_fill;
  logic [FILL_W-1:0]     w_fill_nxt;
  logic                  r_pend;
  logic [NWIN*CNT_W-1:0] w_cnt;
  logic [NWIN-1:0]       w_vote;

  assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

  // Window k spans hist[HIST_W-1-k -: WIN]; k=0 is the oldest window.
  for (genvar k = 0; k < NWIN; k++) begin : g_win
    window_popcount #(
      .WIN   (WIN),
      .CNT_W (CNT_W),
      .THRESH(THRESH)
    ) u_popcount (
      .bits(hist[HIST_W-1-k -: WIN]),
      .cnt (w_cnt[k*CNT_W +: CNT_W]),
      .vote(w_vote[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist      <= '0;
      r_fill    <= '0;
      hist_full <= 1'b0;
      r_pend    <= 1'b0;
      win_cnt   <= '0;
      win_vote  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clr) begin
        hist      <= '0;
        r_fill    <= '0;
        hist_full <= 1'b0;
      end else if (upd_valid) begin
        hist      <= HIST_W'({hist, upd_taken});
        r_fill    <= w_fill_nxt;
        hist_full <= (w_fill_nxt == FILL_MAX);
      end
      // A clear is published like an update so consumers see the zeroed state.
      r_pend    <= clr | upd_valid;
      out_valid <= r_pend;
      if (r_pend) begin
        win_cnt  <= w_cnt;
        win_vote <= w_vote;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_history_window_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_history_window_counter : vectors, corner sequences, random vs model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_history_window_counter;

  localparam int HW = 32;
  localparam int WN = 3;
  localparam int TH = 2;
  localparam int CW = 2;
  localparam int NW = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0, upd_valid = 1'b0, upd_taken = 1'b0, clr = 1'b0;
  logic [HW-1:0]    hist;
  logic [NW*CW-1:0] win_cnt;
  logic [NW-1:0]    win_vote;
  logic             out_valid, hist_full;

  logic v2 = 1'b0, t2 = 1'b0, c2 = 1'b0;
  logic [7:0]  hist2;
  logic [11:0] cnt2;
  logic [3:0]  vote2;
  logic        ov2, full2;

  always #5 clk = ~clk;

  history_window_counter dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_taken(upd_taken), .clr(clr),
    .hist(hist), .win_cnt(win_cnt), .win_vote(win_vote), .out_valid(out_valid),
    .hist_full(hist_full)
  );

  history_window_counter #(.HIST_W(8), .WIN(5), .THRESH(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .upd_valid(v2), .upd_taken(t2), .clr(c2),
    .hist(hist2), .win_cnt(cnt2), .win_vote(vote2), .out_valid(ov2), .hist_full(full2)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference model: list of accepted outcomes, oldest first.
  bit             q[$];
  bit             m_pend, m_ov;
  int             m_cnt[NW];
  logic [NW-1:0]  m_vote;

  function automatic bit hbit(input int j);
    int n = q.size();
    return (j < n) ? q[n-1-j] : 1'b0;
  endfunction

  function automatic int wsum(input int k);
    int s = 0;
    for (int j = HW-k-WN; j <= HW-1-k; j++) s += int'(hbit(j));
    return s;
  endfunction

  task automatic model_edge(input bit rn, input bit v, input bit t, input bit c);
    if (!rn) begin
      q.delete();
      m_pend = 0;
      m_ov   = 0;
      for (int k = 0; k < NW; k++) m_cnt[k] = 0;
      m_vote = '0;
    end else begin
      m_ov = m_pend;
      if (m_pend) begin
        for (int k = 0; k < NW; k++) begin
          m_cnt[k]  = wsum(k);
          m_vote[k] = (m_cnt[k] >= TH);
        end
      end
      m_pend = c | v;
      if (c) q.delete();
      else if (v) q.push_back(t);
    end
  endtask

  task automatic check_model();
    logic [HW-1:0]    eh;
    logic [NW*CW-1:0] ec;
    for (int j = 0; j < HW; j++) eh[j] = hbit(j);
    for (int k = 0; k < NW; k++) ec[k*CW +: CW] = CW'(m_cnt[k]);
    chk("m_hist", 64'(hist), 64'(eh));
    chk("m_cnt", 64'(win_cnt), 64'(ec));
    chk("m_vote", 64'(win_vote), 64'(m_vote));
    chk("m_out_valid", 64'(out_valid), 64'(m_ov));
    chk("m_full", 64'(hist_full), 64'(q.size() >= HW));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst_n, upd_valid, upd_taken, clr);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rn, v, t, c;
    logic [31:0] h;
    logic        ov, full;
    logic [1:0]  c29, c28;
    logic [29:0] vote;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [NW*CW-1:0] ealt;
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 30'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 2'd0, 30'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 2'd0, 2'd0, 30'h0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 2'd1, 2'd0, 30'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2'd1, 2'd0, 30'h0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0, 2'd0, 30'h0};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 2'd0, 2'd0, 30'h0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h3, 1'b1, 1'b0, 2'd1, 2'd0, 30'h0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h7, 1'b1, 1'b0, 2'd2, 2'd1, 30'h2000_0000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 1'b1, 1'b0, 2'd3, 2'd2, 30'h3000_0000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 2'd3, 2'd2, 30'h3000_0000};

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rn; upd_valid = tbl[i].v; upd_taken = tbl[i].t; clr = tbl[i].c;
      tick();
      chk($sformatf("v%0d_hist", i), 64'(hist), 64'(tbl[i].h));
      chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("v%0d_full", i), 64'(hist_full), 64'(tbl[i].full));
      chk($sformatf("v%0d_c29", i), 64'(win_cnt[29*CW +: CW]), 64'(tbl[i].c29));
      chk($sformatf("v%0d_c28", i), 64'(win_cnt[28*CW +: CW]), 64'(tbl[i].c28));
      chk($sformatf("v%0d_vote", i), 64'(win_vote), 64'(tbl[i].vote));
      if (i == 1) chk("p2_reset", 64'({hist2, cnt2, vote2, ov2, full2}), 64'h0);
    end

    // Fill and saturate with alternating outcomes.
    upd_valid = 0; clr = 1; tick(); clr = 0;
    for (int i = 0; i < 40; i++) begin
      upd_valid = 1; upd_taken = (i % 2 == 0);
      tick();
      if (i == 30) chk("full_early", 64'(hist_full), 64'h0);
      if (i == 31) chk("full_rise", 64'(hist_full), 64'h1);
      if (i == 39) chk("full_hold", 64'(hist_full), 64'h1);
    end
    chk("alt_hist", 64'(hist), 64'hAAAA_AAAA);
    upd_valid = 0; tick();
    for (int k = 0; k < NW; k++) ealt[k*CW +: CW] = (k % 2 == 0) ? 2'd2 : 2'd1;
    chk("alt_cnt", 64'(win_cnt), 64'(ealt));

    // Clear colliding with an update on a saturated all-taken history.
    for (int i = 0; i < 32; i++) begin
      upd_valid = 1; upd_taken = 1; tick();
    end
    chk("ones_hist", 64'(hist), 64'hFFFF_FFFF);
    clr = 1; upd_valid = 1; upd_taken = 1; tick();
    chk("clr_hist", 64'(hist), 64'h0);
    chk("clr_full", 64'(hist_full), 64'h0);
    clr = 0; upd_valid = 0; tick();
    chk("clr_ov", 64'(out_valid), 64'h1);
    chk("clr_cnt", 64'(win_cnt), 64'h0);
    chk("clr_vote", 64'(win_vote), 64'h0);

    // Randomised traffic including mid-stream resets and clears.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      clr       = ($urandom_range(0, 19) == 0);
      upd_valid = $urandom_range(0, 1);
      upd_taken = $urandom_range(0, 1);
      tick();
    end
    rst_n = 1; clr = 0; upd_valid = 0; upd_taken = 0;
    tick(); tick();

    // Wide window with unreachable threshold.
    for (int i = 0; i < 8; i++) begin
      v2 = 1; t2 = 1; tick();
    end
    v2 = 0; tick();
    chk("p2_hist", 64'(hist2), 64'hFF);
    chk("p2_cnt", 64'(cnt2), 64'hB6D);
    chk("p2_vote", 64'(vote2), 64'h0);
    chk("p2_ov", 64'(ov2), 64'h1);
    chk("p2_full", 64'(full2), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
